// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// datapath select codes, trap causes and the bundled control-output struct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_M = 4'd2,
    S_MEM_L  = 4'd3,
    S_WB_L   = 4'd4,
    S_MEM_S  = 4'd5,
    S_EXEC_R = 4'd6,
    S_WB_R   = 4'd7,
    S_EXEC_B = 4'd8,
    S_EXEC_J = 4'd9,
    S_EXEC_I = 4'd10,
    S_WB_I   = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ALU_B_RT    = 2'b00,
    ALU_B_FOUR  = 2'b01,
    ALU_B_SIMM  = 2'b10,
    ALU_B_SHIFT = 2'b11
  } alu_b_e;

  typedef enum logic [1:0] {
    PC_SRC_ALU    = 2'b00,
    PC_SRC_ALUOUT = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RS     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_SRC_ALUOUT = 2'b00,
    WB_SRC_MDR    = 2'b01,
    WB_SRC_PC     = 2'b10
  } mem_to_reg_e;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_e;

  // One-hot instruction class; exactly one flag is set for any opcode.
  typedef struct packed {
    logic is_r;
    logic is_jr;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_addi;
    logic is_j;
    logic is_jal;
    logic illegal;
  } instr_class_t;

  typedef struct packed {
    logic        pc_write;
    logic        pc_write_cond;
    logic        branch_ne;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    mem_to_reg_e mem_to_reg;
    reg_dst_e    reg_dst;
    pc_src_e     pc_source;
    alu_op_e     alu_op;
    logic        alu_src_a;
    alu_b_e      alu_src_b;
    logic        reg_write;
    logic        instr_retired;
  } ctrl_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode/funct decoder producing one-hot instruction class flags.
module mips_opcode_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_fields;

  assign opcode        = instr[31:26];
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[25:6];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) cls.is_jr = 1'b1;
        else                   cls.is_r  = 1'b1;
      end
      OP_LW:   cls.is_lw   = 1'b1;
      OP_SW:   cls.is_sw   = 1'b1;
      OP_BEQ:  cls.is_beq  = 1'b1;
      OP_BNE:  cls.is_bne  = 1'b1;
      OP_ADDI: cls.is_addi = 1'b1;
      OP_J:    cls.is_j    = 1'b1;
      OP_JAL:  cls.is_jal  = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: owns the state register, waits on memory with
// a timeout, traps on illegal opcodes/timeouts and counts retired instructions.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter int STATE_W     = 4
) (
  input  logic               cclk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic [1:0]         pc_source,
  output logic [1:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic               instr_retired,
  output logic [CNT_W-1:0]   retired_count
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  trap_cause_e      cause_q, cause_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] count_q, count_d;

  instr_class_t cls;
  ctrl_t        ctrl;
  ctrl_t        ctrl_o;
  logic         waiting;
  logic         retire;

  mips_opcode_decode u_decode (
    .instr (instr),
    .cls   (cls)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ctrl    = '0;
    waiting = 1'b0;

    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALU_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALU_B_SHIFT;
        ctrl.alu_op    = ALU_ADD;
        if (cls.illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
        else if (cls.is_r)                          state_d = S_EXEC_R;
        else if (cls.is_j | cls.is_jal | cls.is_jr) state_d = S_EXEC_J;
        else if (cls.is_beq | cls.is_bne)           state_d = S_EXEC_B;
        else if (cls.is_lw | cls.is_sw)             state_d = S_EXEC_M;
        else if (cls.is_addi)                       state_d = S_EXEC_I;
      end
      S_EXEC_M: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_SIMM;
        state_d        = cls.is_sw ? S_MEM_S : S_MEM_L;
      end
      S_MEM_L: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (mem_ready) state_d = S_WB_L;
        else           waiting = 1'b1;
      end
      S_MEM_S: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
        else           waiting = 1'b1;
      end
      S_WB_L: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_SRC_MDR;
        ctrl.reg_dst    = DST_RT;
        state_d         = S_FETCH;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RD;
        state_d        = S_FETCH;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_SIMM;
        state_d        = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = DST_RT;
        state_d        = S_FETCH;
      end
      S_EXEC_B: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.branch_ne     = cls.is_bne;
        state_d            = S_FETCH;
      end
      S_EXEC_J: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = cls.is_jr ? PC_SRC_RS : PC_SRC_JUMP;
        // JAL links PC+4 (already in PC) into $31 before the jump lands.
        if (cls.is_jal) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = DST_RA;
          ctrl.mem_to_reg = WB_SRC_PC;
        end
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // A ready arriving on the last allowed cycle took the completion branch above.
    if (waiting && (MEM_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end

    retire             = (state_d == S_FETCH) && (state_q != S_FETCH);
    ctrl.instr_retired = retire;

    if (state_d != state_q)                 tmo_d = '0;
    else if (waiting && (MEM_TIMEOUT != 0)) tmo_d = tmo_q + TMO_W'(1);
    else                                    tmo_d = tmo_q;

    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge cclk) begin
    // NOTE: state elements use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      tmo_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  assign ctrl_o        = rst ? '0 : ctrl;
  assign state         = rst ? STATE_W'(S_FETCH) : STATE_W'(state_q);
  assign trap          = !rst && (state_q == S_TRAP);
  assign trap_cause    = rst ? CAUSE_NONE : cause_q;
  assign retired_count = rst ? '0 : count_q;

  assign pc_write      = ctrl_o.pc_write;
  assign pc_write_cond = ctrl_o.pc_write_cond;
  assign branch_ne     = ctrl_o.branch_ne;
  assign iord          = ctrl_o.iord;
  assign mem_read      = ctrl_o.mem_read;
  assign mem_write     = ctrl_o.mem_write;
  assign ir_write      = ctrl_o.ir_write;
  assign mem_to_reg    = ctrl_o.mem_to_reg;
  assign reg_dst       = ctrl_o.reg_dst;
  assign pc_source     = ctrl_o.pc_source;
  assign alu_op        = ctrl_o.alu_op;
  assign alu_src_a     = ctrl_o.alu_src_a;
  assign alu_src_b     = ctrl_o.alu_src_b;
  assign reg_write     = ctrl_o.reg_write;
  assign instr_retired = ctrl_o.instr_retired;

endmodule
